// File: rtl/sc_reg_shifter_pkg.sv
// Shared encodings for the shift/rotate register: shift modes and FSM states.
package sc_reg_shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_ROL = 2'b10,
      SHIFT_ROR = 2'b11
   } shiftMode_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_SHIFTING = 2'b01,
      ST_DONE     = 2'b10
   } shiftState_t;

endpackage

// File: rtl/sc_reg_shifter_if.sv
// Control/data bundle of the shift register; master drives commands, slave is the register.
interface sc_reg_shifter_if #(
   parameter int DW = 8,
   parameter int SW = $clog2(DW)
);
   logic          SC_RegSHIFTER_clear_InLow;
   logic          SC_RegSHIFTER_load_InLow;
   logic          SC_RegSHIFTER_start_InHigh;
   logic [1:0]    SC_RegSHIFTER_mode_InBUS;
   logic [SW-1:0] SC_RegSHIFTER_shamt_InBUS;
   logic          SC_RegSHIFTER_serial_In;
   logic [DW-1:0] SC_RegSHIFTER_data_InBUS;
   logic [DW-1:0] SC_RegSHIFTER_data_OutBUS;
   logic          SC_RegSHIFTER_serial_Out;
   logic          SC_RegSHIFTER_busy_OutHigh;
   logic          SC_RegSHIFTER_done_OutHigh;

   modport master (
      output SC_RegSHIFTER_clear_InLow, SC_RegSHIFTER_load_InLow, SC_RegSHIFTER_start_InHigh,
             SC_RegSHIFTER_mode_InBUS, SC_RegSHIFTER_shamt_InBUS, SC_RegSHIFTER_serial_In,
             SC_RegSHIFTER_data_InBUS,
      input  SC_RegSHIFTER_data_OutBUS, SC_RegSHIFTER_serial_Out,
             SC_RegSHIFTER_busy_OutHigh, SC_RegSHIFTER_done_OutHigh
   );

   modport slave (
      input  SC_RegSHIFTER_clear_InLow, SC_RegSHIFTER_load_InLow, SC_RegSHIFTER_start_InHigh,
             SC_RegSHIFTER_mode_InBUS, SC_RegSHIFTER_shamt_InBUS, SC_RegSHIFTER_serial_In,
             SC_RegSHIFTER_data_InBUS,
      output SC_RegSHIFTER_data_OutBUS, SC_RegSHIFTER_serial_Out,
             SC_RegSHIFTER_busy_OutHigh, SC_RegSHIFTER_done_OutHigh
   );
endinterface

// File: rtl/sc_reg_shifter_step.sv
// One-position shifter/rotator; fill only matters for the logical shifts.
module sc_reg_shifter_step
   import sc_reg_shifter_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] stepData,
   input  shiftMode_t   stepMode,
   input  logic         stepFill,
   output logic [W-1:0] stepNext,
   output logic         stepOut
);

   always_comb begin
      stepNext = stepData;
      stepOut  = 1'b0;
      case (stepMode)
         SHIFT_SLL: begin stepNext = {stepData[W-2:0], stepFill};    stepOut = stepData[W-1]; end
         SHIFT_SRL: begin stepNext = {stepFill, stepData[W-1:1]};    stepOut = stepData[0];   end
         SHIFT_ROL: begin stepNext = {stepData[W-2:0], stepData[W-1]}; stepOut = stepData[W-1]; end
         SHIFT_ROR: begin stepNext = {stepData[0], stepData[W-1:1]}; stepOut = stepData[0];   end
         default: ;
      endcase
   end

endmodule

// File: rtl/sc_reg_shifter.sv
// Load/clear register with a one-bit-per-clock shift/rotate engine and serial chaining.
module sc_reg_shifter
   import sc_reg_shifter_pkg::*;
#(
   parameter int                            RegSHIFTER_DATAWIDTH  = 8,
   parameter int                            RegSHIFTER_SHAMTWIDTH = $clog2(RegSHIFTER_DATAWIDTH),
   parameter logic [RegSHIFTER_DATAWIDTH-1:0] RegSHIFTER_RESETVALUE = 1
) (
   input  logic            SC_RegSHIFTER_CLOCK_50,
   input  logic            SC_RegSHIFTER_RESET_InHigh,
   sc_reg_shifter_if.slave regBus
);

   localparam int W  = RegSHIFTER_DATAWIDTH;
   localparam int SW = RegSHIFTER_SHAMTWIDTH;

   shiftState_t state;
   shiftMode_t  modeLatched;
   logic [SW-1:0] stepCnt;
   logic [W-1:0]  dataReg, stepNext;
   logic          serialReg, stepOut;

   sc_reg_shifter_step #(.W(W)) stepUnit (
      .stepData (dataReg),
      .stepMode (modeLatched),
      .stepFill (regBus.SC_RegSHIFTER_serial_In),
      .stepNext (stepNext),
      .stepOut  (stepOut)
   );

   always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
      if (SC_RegSHIFTER_RESET_InHigh) begin
         dataReg     <= RegSHIFTER_RESETVALUE;
         serialReg   <= 1'b0;
         stepCnt     <= '0;
         modeLatched <= SHIFT_SLL;
         state       <= ST_IDLE;
      end else if (!regBus.SC_RegSHIFTER_clear_InLow) begin
         dataReg   <= '0;
         serialReg <= 1'b0;
         stepCnt   <= '0;
         state     <= ST_IDLE;
      end else if (!regBus.SC_RegSHIFTER_load_InLow && state != ST_SHIFTING) begin
         dataReg <= regBus.SC_RegSHIFTER_data_InBUS;
         state   <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (regBus.SC_RegSHIFTER_start_InHigh) begin
               modeLatched <= shiftMode_t'(regBus.SC_RegSHIFTER_mode_InBUS);
               stepCnt     <= regBus.SC_RegSHIFTER_shamt_InBUS;
               state       <= (regBus.SC_RegSHIFTER_shamt_InBUS == '0) ? ST_DONE : ST_SHIFTING;
            end
            ST_SHIFTING: begin
               dataReg   <= stepNext;
               serialReg <= stepOut;
               stepCnt   <= stepCnt - SW'(1);
               if (stepCnt == SW'(1)) state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Status is decoded straight from the state register, so nothing combinational reaches the outputs.
   assign regBus.SC_RegSHIFTER_data_OutBUS  = dataReg;
   assign regBus.SC_RegSHIFTER_serial_Out   = serialReg;
   assign regBus.SC_RegSHIFTER_busy_OutHigh = (state == ST_SHIFTING);
   assign regBus.SC_RegSHIFTER_done_OutHigh = (state == ST_DONE);

endmodule

// File: tb/tb_sc_reg_shifter.sv
// Scoreboard bench: per-cycle expectations are queued with the stimulus and checked after each edge.
module tb_sc_reg_shifter;

   typedef struct {
      string      tag;
      logic [7:0] data;
      int         so;     // -1: serial_Out not defined for this cycle
      logic       busy;
      logic       done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];

   sc_reg_shifter_if #(.DW(8), .SW(3)) regBus ();

   sc_reg_shifter #(
      .RegSHIFTER_DATAWIDTH (8),
      .RegSHIFTER_SHAMTWIDTH(3),
      .RegSHIFTER_RESETVALUE(8'h01)
   ) dut (
      .SC_RegSHIFTER_CLOCK_50    (clk),
      .SC_RegSHIFTER_RESET_InHigh(rst),
      .regBus                    (regBus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Queue the expected post-edge state, take one edge, then drain the scoreboard against the DUT.
   task automatic cyc(input string tag, input logic [7:0] d, input int so, input logic b, input logic dn);
      exp_t e;
      sbq.push_back('{tag, d, so, b, dn});
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({e.tag, ".data"}, 32'(regBus.SC_RegSHIFTER_data_OutBUS), 32'(e.data));
         if (e.so >= 0) chk({e.tag, ".sout"}, 32'(regBus.SC_RegSHIFTER_serial_Out), 32'(e.so));
         chk({e.tag, ".busy"}, 32'(regBus.SC_RegSHIFTER_busy_OutHigh), 32'(e.busy));
         chk({e.tag, ".done"}, 32'(regBus.SC_RegSHIFTER_done_OutHigh), 32'(e.done));
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] d, input logic st,
                        input logic [1:0] m, input logic [2:0] sh, input logic sin);
      regBus.SC_RegSHIFTER_load_InLow   = ld;
      regBus.SC_RegSHIFTER_data_InBUS   = d;
      regBus.SC_RegSHIFTER_start_InHigh = st;
      regBus.SC_RegSHIFTER_mode_InBUS   = m;
      regBus.SC_RegSHIFTER_shamt_InBUS  = sh;
      regBus.SC_RegSHIFTER_serial_In    = sin;
   endtask

   task automatic idle_in();
      drive(1'b1, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0);
   endtask

   initial begin
      regBus.SC_RegSHIFTER_clear_InLow = 1'b1;
      idle_in();
      cyc("rst0", 8'h01, 0, 1'b0, 1'b0);
      cyc("rst1", 8'h01, 0, 1'b0, 1'b0);
      rst = 1'b0;

      // SLL by 3 on 0xA5 with zero fill
      drive(1'b0, 8'hA5, 1'b0, 2'b00, 3'd0, 1'b0);
      cyc("ldA5", 8'hA5, -1, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 2'b00, 3'd3, 1'b0);
      cyc("sll.s0", 8'hA5, -1, 1'b1, 1'b0);
      idle_in();
      cyc("sll.s1", 8'h4A, 1, 1'b1, 1'b0);
      cyc("sll.s2", 8'h94, 0, 1'b1, 1'b0);
      cyc("sll.s3", 8'h28, 1, 1'b0, 1'b1);
      cyc("sll.end", 8'h28, 1, 1'b0, 1'b0);

      // ROR by 1 on 0x81
      drive(1'b0, 8'h81, 1'b0, 2'b00, 3'd0, 1'b0);
      cyc("ld81", 8'h81, -1, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 2'b11, 3'd1, 1'b0);
      cyc("ror.s0", 8'h81, -1, 1'b1, 1'b0);
      idle_in();
      cyc("ror.s1", 8'hC0, 1, 1'b0, 1'b1);
      cyc("ror.end", 8'hC0, 1, 1'b0, 1'b0);

      // shamt=0, then a start held through DONE is ignored until IDLE
      drive(1'b0, 8'h5A, 1'b0, 2'b00, 3'd0, 1'b0);
      cyc("ld5A", 8'h5A, -1, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 2'b01, 3'd0, 1'b1);
      cyc("z.s0", 8'h5A, -1, 1'b0, 1'b1);
      drive(1'b1, 8'h00, 1'b1, 2'b11, 3'd1, 1'b0);
      cyc("z.donestart", 8'h5A, -1, 1'b0, 1'b0);
      cyc("b2b.s0", 8'h5A, -1, 1'b1, 1'b0);
      idle_in();
      cyc("b2b.s1", 8'h2D, 0, 1'b0, 1'b1);

      // SRL by 7 on 0xFF aborted by clear after two steps
      drive(1'b0, 8'hFF, 1'b0, 2'b00, 3'd0, 1'b0);
      cyc("ldFF", 8'hFF, -1, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 2'b01, 3'd7, 1'b0);
      cyc("srl.s0", 8'hFF, -1, 1'b1, 1'b0);
      idle_in();
      cyc("srl.s1", 8'h7F, 1, 1'b1, 1'b0);
      cyc("srl.s2", 8'h3F, 1, 1'b1, 1'b0);
      regBus.SC_RegSHIFTER_clear_InLow = 1'b0;
      cyc("clr", 8'h00, 0, 1'b0, 1'b0);
      regBus.SC_RegSHIFTER_clear_InLow = 1'b1;
      cyc("clr.after1", 8'h00, 0, 1'b0, 1'b0);
      cyc("clr.after2", 8'h00, 0, 1'b0, 1'b0);

      // load and start during SHIFTING are both ignored
      drive(1'b0, 8'h0F, 1'b0, 2'b00, 3'd0, 1'b0);
      cyc("ld0F", 8'h0F, -1, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 2'b10, 3'd2, 1'b1);
      cyc("rol.s0", 8'h0F, -1, 1'b1, 1'b0);
      drive(1'b0, 8'h12, 1'b1, 2'b00, 3'd5, 1'b1);
      cyc("rol.s1", 8'h1E, 0, 1'b1, 1'b0);
      idle_in();
      cyc("rol.s2", 8'h3C, 0, 1'b0, 1'b1);
      cyc("rol.end", 8'h3C, 0, 1'b0, 0);

      // SRL with ones fill, reset mid-shift
      drive(1'b1, 8'h00, 1'b1, 2'b01, 3'd4, 1'b1);
      cyc("rs.s0", 8'h3C, -1, 1'b1, 1'b0);
      regBus.SC_RegSHIFTER_start_InHigh = 1'b0;
      cyc("rs.s1", 8'h9E, 0, 1'b1, 1'b0);
      rst = 1'b1;
      cyc("rs.rst", 8'h01, 0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc("rs.after1", 8'h01, 0, 1'b0, 1'b0);
      cyc("rs.after2", 8'h01, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
